// File: rtl/hazard_ctrl_pipe_if.sv
// Decode-side hazard bus between the datapath (master) and hazard_ctrl_pipe (slave).
// Source port i occupies SrcD[i*RA_W +: RA_W]; its select is ForwardE[i*2 +: 2].
interface hazard_ctrl_pipe_if #(
    parameter int RA_W    = 4,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*RA_W-1:0] SrcD;
    logic [NUM_SRC-1:0]      SrcValidD;
    logic [RA_W-1:0]         DstD;
    logic                    RegWriteD;
    logic                    MemtoRegD;
    logic                    PCSrcD;
    logic                    BranchTakenE;
    logic [NUM_SRC*2-1:0]    ForwardE;
    logic                    StallF;
    logic                    StallD;
    logic                    FlushD;
    logic                    FlushE;

    modport master (
        output SrcD, SrcValidD, DstD, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
        input  ForwardE, StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  SrcD, SrcValidD, DstD, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
        output ForwardE, StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// Hazard/forwarding controller for the 5-stage core: E/M/W register-tag pipeline driving
// forward selects, load-use stalls and PC/branch flushes. Optional counters: HAZARD_PERF_EN.
module hazard_ctrl_pipe #(
    parameter int RA_W    = 4,
    parameter int NUM_SRC = 2,
    parameter int PC_REG  = 15
) (
    input  logic              clk,
    input  logic              reset,
    hazard_ctrl_pipe_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
`endif
);
    localparam logic [RA_W-1:0] PC_TAG = RA_W'(PC_REG);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // E stage tags (_p0)
    logic [NUM_SRC*RA_W-1:0] src_p0;
    logic [NUM_SRC-1:0]      src_vld_p0;
    logic [RA_W-1:0]         dst_p0;
    logic                    wr_p0;
    logic                    ld_p0;
    logic                    pc_p0;
    // M stage tags (_p1)
    logic [RA_W-1:0]         dst_p1;
    logic                    wr_p1;
    logic                    pc_p1;
    // W stage tags (_p2)
    logic [RA_W-1:0]         dst_p2;
    logic                    wr_p2;
    logic                    pc_p2;

    logic [NUM_SRC*2-1:0]    fwd;
    logic                    ld_use;
    logic                    ld_stall;
    logic                    pc_pend;
    logic                    stall_f;
    logic                    stall_d;
    logic                    flush_d;
    logic                    flush_e;

    function automatic logic tag_hit(input logic            vld,
                                     input logic            wr,
                                     input logic [RA_W-1:0] dst,
                                     input logic [RA_W-1:0] src);
        return vld & wr & (dst == src) & (dst != PC_TAG);
    endfunction

    // The younger producer in M wins over W.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_MEM;
        else if (hit_w) return FWD_WB;
        else            return FWD_RF;
    endfunction

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction
`endif

    // D -> E boundary: a flushed E stage becomes an all-zero bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_p0     <= '0;
            src_vld_p0 <= '0;
            dst_p0     <= '0;
            wr_p0      <= 1'b0;
            ld_p0      <= 1'b0;
            pc_p0      <= 1'b0;
        end else if (flush_e) begin
            src_p0     <= '0;
            src_vld_p0 <= '0;
            dst_p0     <= '0;
            wr_p0      <= 1'b0;
            ld_p0      <= 1'b0;
            pc_p0      <= 1'b0;
        end else begin
            src_p0     <= hz.SrcD;
            src_vld_p0 <= hz.SrcValidD;
            dst_p0     <= hz.DstD;
            wr_p0      <= hz.RegWriteD;
            ld_p0      <= hz.MemtoRegD;
            pc_p0      <= hz.PCSrcD;
        end
    end

    // E -> M and M -> W boundaries: advance every edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_p1 <= '0;
            wr_p1  <= 1'b0;
            pc_p1  <= 1'b0;
            dst_p2 <= '0;
            wr_p2  <= 1'b0;
            pc_p2  <= 1'b0;
        end else begin
            dst_p1 <= dst_p0;
            wr_p1  <= wr_p0;
            pc_p1  <= pc_p0;
            dst_p2 <= dst_p1;
            wr_p2  <= wr_p1;
            pc_p2  <= pc_p1;
        end
    end

    always_comb begin
        fwd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd[i*2 +: 2] = fwd_sel(
                tag_hit(src_vld_p0[i], wr_p1, dst_p1, src_p0[i*RA_W +: RA_W]),
                tag_hit(src_vld_p0[i], wr_p2, dst_p2, src_p0[i*RA_W +: RA_W]));
        end
    end

    always_comb begin
        ld_use = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            ld_use = ld_use | (hz.SrcValidD[j] & (hz.SrcD[j*RA_W +: RA_W] == dst_p0));
        end
    end

    // StallD and FlushD may both be high; the datapath decides which one wins.
    assign ld_stall = ld_p0 & wr_p0 & (dst_p0 != PC_TAG) & ld_use;
    assign pc_pend  = hz.PCSrcD | pc_p0 | pc_p1;
    assign stall_f  = ld_stall | pc_pend;
    assign stall_d  = ld_stall;
    assign flush_d  = pc_pend | pc_p2 | hz.BranchTakenE;
    assign flush_e  = ld_stall | hz.BranchTakenE;

    assign hz.ForwardE = fwd;
    assign hz.StallF   = stall_f;
    assign hz.StallD   = stall_d;
    assign hz.FlushD   = flush_d;
    assign hz.FlushE   = flush_e;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall_f) begin
                StallCnt <= sat_inc(StallCnt);
            end
            if (flush_e | flush_d) begin
                FlushCnt <= sat_inc(FlushCnt);
            end
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed hazard scenarios plus randomized traffic checked
// against an in-flight instruction model. Build with HAZARD_PERF_EN for the 3-port counter case.
module tb_hazard_ctrl_pipe;
`ifdef HAZARD_PERF_EN
    localparam int NS = 3;
`else
    localparam int NS = 2;
`endif
    localparam int RW = 4;
    localparam logic [RW-1:0] PCR = 4'd15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_pipe_if #(.RA_W(RW), .NUM_SRC(NS)) hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_ctrl_pipe #(.RA_W(RW), .NUM_SRC(NS), .PC_REG(15)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt (stall_cnt),
        .FlushCnt (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [NS*RW-1:0] src;
        logic [NS-1:0]    vld;
        logic [RW-1:0]    dst;
        logic             wr;
        logic             ld;
        logic             pc;
    } instr_t;

    // Instructions in flight: index 0 = E, 1 = M, 2 = W.
    instr_t      in_flight[3];
    logic [31:0] m_scnt;
    logic [31:0] m_fcnt;

    int checks = 0;
    int errors = 0;

    logic [NS*2-1:0] obs_fwd;
    logic obs_sf, obs_sd, obs_fd, obs_fe;
    logic [4:0] pc_fd, pc_sf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input int s0, input int s1, input int s2, input logic [2:0] v,
                                  input int dst, input logic wr, input logic ld, input logic pc);
        instr_t r;
        int s[3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        r = '0;
        for (int i = 0; i < NS; i++) r.src[i*RW +: RW] = s[i][RW-1:0];
        r.vld = v[NS-1:0];
        r.dst = dst[RW-1:0];
        r.wr  = wr;
        r.ld  = ld;
        r.pc  = pc;
        return r;
    endfunction

    function automatic int rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 15 : r;
    endfunction

    function automatic instr_t rnd_instr();
        return mk(rnd_reg(), rnd_reg(), rnd_reg(), 3'($urandom_range(0, 7)), rnd_reg(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 3; s++) in_flight[s] = '0;
        m_scnt = '0;
        m_fcnt = '0;
    endfunction

    // Each E reader takes the youngest older writer of its register (M before W); R15 never forwards.
    function automatic logic [NS*2-1:0] m_fwd();
        logic [NS*2-1:0] f;
        logic [RW-1:0] r;
        f = '0;
        for (int i = 0; i < NS; i++) begin
            r = in_flight[0].src[i*RW +: RW];
            if (in_flight[0].vld[i] && r != PCR) begin
                for (int s = 2; s >= 1; s--) begin
                    if (in_flight[s].wr && in_flight[s].dst == r) f[i*2 +: 2] = (s == 1) ? 2'b10 : 2'b01;
                end
            end
        end
        return f;
    endfunction

    function automatic logic m_ldstall(input instr_t d);
        instr_t e;
        e = in_flight[0];
        if (!(e.ld && e.wr && e.dst != PCR)) return 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (d.vld[j] && d.src[j*RW +: RW] == e.dst) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input instr_t d, input logic br);
        logic ls, pp, esf, esd, efd, efe;
        @(negedge clk);
        hif.SrcD         = d.src;
        hif.SrcValidD    = d.vld;
        hif.DstD         = d.dst;
        hif.RegWriteD    = d.wr;
        hif.MemtoRegD    = d.ld;
        hif.PCSrcD       = d.pc;
        hif.BranchTakenE = br;
        #1;
        ls  = m_ldstall(d);
        pp  = d.pc | in_flight[0].pc | in_flight[1].pc;
        esf = ls | pp;
        esd = ls;
        efd = pp | in_flight[2].pc | br;
        efe = ls | br;
        obs_fwd = hif.ForwardE;
        obs_sf  = hif.StallF;
        obs_sd  = hif.StallD;
        obs_fd  = hif.FlushD;
        obs_fe  = hif.FlushE;
        chk("fwd",    obs_fwd, m_fwd());
        chk("stallf", obs_sf, esf);
        chk("stalld", obs_sd, esd);
        chk("flushd", obs_fd, efd);
        chk("flushe", obs_fe, efe);
`ifdef HAZARD_PERF_EN
        chk("stallcnt", stall_cnt, m_scnt);
        chk("flushcnt", flush_cnt, m_fcnt);
`endif
        @(posedge clk);
        if (reset) begin
            if (esf && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if ((efd || efe) && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            in_flight[2] = in_flight[1];
            in_flight[1] = in_flight[0];
            in_flight[0] = efe ? '0 : d;
        end
    endtask

    // Asserted away from the clock edge, released 2 time units after a rising edge.
    task automatic pulse_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_fwd", hif.ForwardE, '0);
`ifdef HAZARD_PERF_EN
        chk("rst_stallcnt", stall_cnt, 32'd0);
        chk("rst_flushcnt", flush_cnt, 32'd0);
`endif
        repeat (n) step(rnd_instr(), 1'($urandom_range(0, 1)));
        #2 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        hif.SrcD = '0; hif.SrcValidD = '0; hif.DstD = '0; hif.RegWriteD = 1'b0;
        hif.MemtoRegD = 1'b0; hif.PCSrcD = 1'b0; hif.BranchTakenE = 1'b0;
        model_clear();

        // In reset: only D-stage inputs drive stalls/flushes
        step(mk(1, 1, 1, 3'b111, 1, 1, 1, 1), 1'b0);
        chk("rst_d_stallf", obs_sf, 1'b1);
        chk("rst_d_flushd", obs_fd, 1'b1);
        chk("rst_d_flushe", obs_fe, 1'b0);
        chk("rst_d_fwd",    obs_fwd, '0);
        #2 reset = 1'b1;

        // ALU chain with 0, 1 and 2 unrelated instructions between producer and consumer
        step(mk(0, 0, 0, 3'b000, 1, 1, 0, 0), 1'b0);
        step(mk(1, 3, 0, 3'b011, 2, 1, 0, 0), 1'b0);
        #1 chk("alu_gap0", hif.ForwardE[1:0], 2'b10);
        step(mk(0, 0, 0, 3'b000, 1, 1, 0, 0), 1'b0);
        step(mk(0, 0, 0, 3'b000, 0, 0, 0, 0), 1'b0);
        step(mk(1, 3, 0, 3'b011, 2, 1, 0, 0), 1'b0);
        #1 chk("alu_gap1", hif.ForwardE[1:0], 2'b01);
        step(mk(0, 0, 0, 3'b000, 1, 1, 0, 0), 1'b0);
        step(mk(0, 0, 0, 3'b000, 0, 0, 0, 0), 1'b0);
        step(mk(0, 0, 0, 3'b000, 0, 0, 0, 0), 1'b0);
        step(mk(1, 3, 0, 3'b011, 2, 1, 0, 0), 1'b0);
        #1 chk("alu_gap2", hif.ForwardE[1:0], 2'b00);

        // Load-use: one stall cycle, then both ports forwarded from W
        step(mk(0, 0, 0, 3'b000, 4, 1, 1, 0), 1'b0);
        step(mk(4, 4, 0, 3'b011, 5, 1, 0, 0), 1'b0);
        chk("ld_stallf", obs_sf, 1'b1);
        chk("ld_stalld", obs_sd, 1'b1);
        chk("ld_flushe", obs_fe, 1'b1);
        step(mk(4, 4, 0, 3'b011, 5, 1, 0, 0), 1'b0);
        chk("ld_once", obs_sd, 1'b0);
        #1 chk("ld_fwd", hif.ForwardE[3:0], 4'b0101);

        // R15 is never forwarded
        step(mk(0, 0, 0, 3'b000, 15, 1, 0, 0), 1'b0);
        step(mk(15, 15, 15, 3'b111, 6, 1, 0, 0), 1'b0);
        #1 chk("r15_m", hif.ForwardE, '0);
        step(mk(15, 15, 15, 3'b111, 6, 1, 0, 0), 1'b0);
        #1 chk("r15_w", hif.ForwardE[1:0], 2'b00);

        // PC write: FlushD for 4 cycles, StallF for 3
        repeat (3) step(mk(0, 0, 0, 3'b000, 0, 0, 0, 0), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(mk(0, 0, 0, 3'b000, 0, 0, 0, (k == 0)), 1'b0);
            pc_fd[k] = obs_fd;
            pc_sf[k] = obs_sf;
        end
        chk("pc_flushd_seq", pc_fd, 5'b01111);
        chk("pc_stallf_seq", pc_sf, 5'b00111);

        // Branch taken together with load-use
        step(mk(0, 0, 0, 3'b000, 6, 1, 1, 0), 1'b0);
        step(mk(6, 0, 0, 3'b001, 7, 1, 0, 0), 1'b1);
        chk("br_ld_flushd", obs_fd, 1'b1);
        chk("br_ld_flushe", obs_fe, 1'b1);
        chk("br_ld_stalld", obs_sd, 1'b1);
        #1 chk("br_ld_bubble", hif.ForwardE, '0);

`ifdef HAZARD_PERF_EN
        pulse_reset(1);
        for (int k = 0; k < 5; k++) begin
            step(mk(0, 0, 0, 3'b000, 7, 1, 1, 0), 1'b0);
            step(mk(7, 0, 0, 3'b001, 8, 1, 0, 0), 1'b0);
            step(mk(7, 0, 0, 3'b001, 8, 1, 0, 0), 1'b0);
        end
        #1;
        chk("perf_stallcnt", stall_cnt, 32'd5);
        chk("perf_flushcnt", flush_cnt, 32'd5);
        step(mk(0, 0, 0, 3'b000, 9, 1, 0, 0), 1'b0);
        step(mk(0, 0, 9, 3'b100, 10, 1, 0, 0), 1'b0);
        #1 chk("port2_fwd", hif.ForwardE[5:4], 2'b10);
        pulse_reset(2);
`endif

        // Randomized traffic with occasional mid-operation resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset($urandom_range(1, 3));
            else step(rnd_instr(), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
